// File: rtl/des_sbox_pkg.sv
// des_sbox_pkg: DES S-box tables, P permutation and engine FSM states shared by the S-box engine.
package des_sbox_pkg;

    localparam int NUM_SBOX   = 8;
    localparam int SBOX_IN_W  = 6;
    localparam int SBOX_OUT_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Indexed [box][row*16+col]; box 0 is S1.
    localparam logic [SBOX_OUT_W-1:0] SBOX_TABLE [NUM_SBOX][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    // 1-based source bit (MSB = bit 1) for each output bit, MSB first.
    localparam int P_TABLE [32] = '{
        16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
         2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25
    };

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            r[31-i] = x[5'(32 - P_TABLE[i])];
        return r;
    endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// des_sbox_lut: combinational lookup of one 6-bit chunk in the selected DES S-box.
module des_sbox_lut
    import des_sbox_pkg::*;
(
    input  logic [2:0]            box,
    input  logic [SBOX_IN_W-1:0]  chunk,
    output logic [SBOX_OUT_W-1:0] nibble
);

    // Row is the outer bit pair, column the inner four bits.
    assign nibble = SBOX_TABLE[box][{chunk[5], chunk[0], chunk[4:1]}];

endmodule

// File: rtl/des_sbox_engine.sv
// des_sbox_engine: DES S1..S8 substitution evaluating LANES boxes per cycle with valid/ready handshakes.
// Define DES_SBOX_PPERM_EN to apply the P permutation to SBOX_OUT.
module des_sbox_engine
    import des_sbox_pkg::*;
#(
    parameter int LANES = 8
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [47:0] SBOX_IN,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] SBOX_OUT,
    output logic        BUSY
);

    localparam int ITER = NUM_SBOX / LANES;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [47:0]     in_reg;
    logic [31:0]     res;
    logic            last;
    logic [2:0]      box   [LANES];
    logic [5:0]      chunk [LANES];
    logic [3:0]      nib   [LANES];

    assign last = cnt == CW'(ITER - 1);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign box[i]   = 3'(int'(cnt) * LANES + i);
        assign chunk[i] = in_reg[6'(47 - 6 * int'(box[i])) -: 6];
        des_sbox_lut u_lut (
            .box    (box[i]),
            .chunk  (chunk[i]),
            .nibble (nib[i])
        );
    end

    always_comb begin
        next_state = state;
        next_state = (state == IDLE && IN_VALID)  ? RUN  :
                     (state == RUN  && last)      ? DONE :
                     (state == DONE && OUT_READY) ? IDLE : state;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            in_reg <= '0;
            res    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && IN_VALID) begin
                in_reg <= SBOX_IN;
                cnt    <= '0;
            end
            if (state == RUN) begin
                cnt <= last ? '0 : cnt + 1'b1;
                for (int l = 0; l < LANES; l++)
                    res[5'(31 - 4 * int'(box[l])) -: 4] <= nib[l];
            end
        end
    end

    assign IN_READY  = state == IDLE && !RST;
    assign OUT_VALID = state == DONE;
    assign BUSY      = state != IDLE;

`ifdef DES_SBOX_PPERM_EN
    assign SBOX_OUT = p_perm(res);
`else
    assign SBOX_OUT = res;
`endif

endmodule

// File: tb/tb_des_sbox_engine.sv
// tb_des_sbox_engine: scoreboard bench for des_sbox_engine at LANES 8, 1, 2 and 4 side by side.
module tb_des_sbox_engine;

    localparam int NI = 4;
    localparam int LN [NI] = '{8, 1, 2, 4};

    // Each row holds 16 nibbles, column 0 in the top nibble; index box*4+row.
    localparam logic [63:0] SROW [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    localparam int PT [32] = '{
        16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
         2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [NI];
    logic        out_ready [NI];
    logic [47:0] sbox_in   [NI];
    logic        in_ready  [NI];
    logic        out_valid [NI];
    logic        busy      [NI];
    logic [31:0] sbox_out  [NI];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        des_sbox_engine #(.LANES(LN[g])) u_dut (
            .CLK       (clk),
            .RST       (rst),
            .IN_VALID  (in_valid[g]),
            .IN_READY  (in_ready[g]),
            .SBOX_IN   (sbox_in[g]),
            .OUT_VALID (out_valid[g]),
            .OUT_READY (out_ready[g]),
            .SBOX_OUT  (sbox_out[g]),
            .BUSY      (busy[g])
        );
    end

    function automatic logic [31:0] model(input logic [47:0] d);
        logic [31:0] r;
        logic [31:0] p;
        logic [5:0]  c;
        logic [63:0] w;
        int          row;
        int          col;
        r = '0;
        p = '0;
        for (int b = 0; b < 8; b++) begin
            c   = d[47 - 6 * b -: 6];
            row = int'({c[5], c[0]});
            col = int'(c[4:1]);
            w   = SROW[4 * b + row];
            r[31 - 4 * b -: 4] = w[63 - 4 * col -: 4];
        end
        for (int i = 0; i < 32; i++)
            p[31 - i] = r[32 - PT[i]];
`ifdef DES_SBOX_PPERM_EN
        r = p;
`endif
        return r;
    endfunction

    task automatic do_block(input int k, input logic [47:0] d, input int hold);
        logic [31:0] e;
        int          lat;
        in_valid[k] = 1'b1;
        sbox_in[k]  = d;
        exp_q.push_back(model(d));
        checks++;
        if (in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready lanes=%0d got=%b want=1", LN[k], in_ready[k]);
        end
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        sbox_in[k]  = '0;
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 8 / LN[k]) begin
            errors++;
            $display("FAIL latency lanes=%0d got=%0d want=%0d", LN[k], lat, 8 / LN[k]);
        end
        e = exp_q.pop_front();
        checks++;
        if (sbox_out[k] !== e) begin
            errors++;
            $display("FAIL data lanes=%0d in=%h got=%h want=%h", LN[k], d, sbox_out[k], e);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0 || busy[k] !== 1'b1 || sbox_out[k] !== e) begin
                errors++;
                $display("FAIL hold lanes=%0d cyc=%0d got v=%b r=%b b=%b out=%h want v=1 r=0 b=1 out=%h",
                         LN[k], h, out_valid[k], in_ready[k], busy[k], sbox_out[k], e);
            end
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        checks++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL release lanes=%0d got v=%b r=%b b=%b want v=0 r=1 b=0",
                     LN[k], out_valid[k], in_ready[k], busy[k]);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || sbox_out[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state lanes=%0d got r=%b v=%b b=%b out=%h want 0 0 0 00000000",
                         LN[k], in_ready[k], out_valid[k], busy[k], sbox_out[k]);
            end
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release lanes=%0d got r=%b want 1", LN[k], in_ready[k]);
            end
        end
    endtask

    task automatic test_zeros();
        do_block(0, 48'h0, 0);
`ifndef DES_SBOX_PPERM_EN
        checks++;
        if (sbox_out[0] !== 32'hEFA72C4D) begin
            errors++;
            $display("FAIL zeros_const got=%h want=EFA72C4D", sbox_out[0]);
        end
`endif
    endtask

    task automatic test_ones();
        do_block(1, 48'hFFFF_FFFF_FFFF, 0);
`ifndef DES_SBOX_PPERM_EN
        checks++;
        if (sbox_out[1] !== 32'hD9CE3DCB) begin
            errors++;
            $display("FAIL ones_const got=%h want=D9CE3DCB", sbox_out[1]);
        end
`endif
    endtask

    task automatic test_s4_sweep();
        int ks [3] = '{2, 3, 0};
        for (int j = 0; j < 3; j++)
            for (int v = 0; v < 64; v++)
                do_block(ks[j], 48'(v) << 24, 0);
    endtask

    task automatic test_backpressure();
        do_block(1, 48'h0123_4567_89AB, 10);
        do_block(3, 48'hFEDC_BA98_7654, 10);
    endtask

    task automatic test_back_to_back();
        do_block(1, 48'h1357_9BDF_0246, 0);
        do_block(1, 48'h8ACE_0246_1357, 0);
        do_block(2, 48'hA5A5_5A5A_C3C3, 0);
        do_block(2, 48'h5A5A_A5A5_3C3C, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++)
            for (int k = 0; k < NI; k++)
                do_block(k, 48'({$urandom(), $urandom()}), n % 2);
    endtask

    task automatic test_reset_mid_run();
        in_valid[1] = 1'b1;
        sbox_in[1]  = 48'hDEAD_BEEF_CAFE;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_busy got b=%b v=%b want b=1 v=0", busy[1], out_valid[1]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid[1] !== 1'b0 || sbox_out[1] !== 32'h0 || busy[1] !== 1'b0 || in_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset got v=%b out=%h b=%b r=%b want v=0 out=00000000 b=0 r=0",
                     out_valid[1], sbox_out[1], busy[1], in_ready[1]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_release got r=%b v=%b want r=1 v=0", in_ready[1], out_valid[1]);
        end
        @(posedge clk); #1;
        do_block(1, 48'h0F0F_F0F0_1234, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            sbox_in[k]   = '0;
        end
        test_reset();
        @(posedge clk); #1;
        test_zeros();
        test_ones();
        test_s4_sweep();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
